// File: rtl/snake_turn_queue_ctrl.sv
// Per-player turn FIFO committing one turn per tick into a registered heading; latency 1 from tick.
// Full FIFO drops the event with a queue_overflow pulse; DIR_CTRL_BYPASS_EN applies an event on an empty-FIFO tick directly.
package game_pkg;
  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    UP    = 3'd1,
    RIGHT = 3'd2,
    DOWN  = 3'd3,
    LEFT  = 3'd4
  } directions;
endpackage

module snake_turn_queue_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         restart,
  input  logic                         tick,
  input  logic [NUM_PLAYERS-1:0]       turn_right,
  input  logic [NUM_PLAYERS-1:0]       turn_left,
  output logic [NUM_PLAYERS-1:0][2:0]  direction,
  output logic [NUM_PLAYERS-1:0]       dir_changed,
  output logic [NUM_PLAYERS-1:0]       queue_overflow
);
  import game_pkg::*;

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

  logic [NUM_PLAYERS-1:0]                  btn_r_q, btn_r_d;
  logic [NUM_PLAYERS-1:0]                  btn_l_q, btn_l_d;
  logic [NUM_PLAYERS-1:0][QUEUE_DEPTH-1:0] mem_q, mem_d;
  logic [NUM_PLAYERS-1:0][PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [NUM_PLAYERS-1:0][PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [NUM_PLAYERS-1:0][CNT_W-1:0]       count_q, count_d;
  logic [NUM_PLAYERS-1:0][2:0]             direction_q, direction_d;
  logic [NUM_PLAYERS-1:0]                  dir_changed_q, dir_changed_d;
  logic [NUM_PLAYERS-1:0]                  queue_overflow_q, queue_overflow_d;

  logic [NUM_PLAYERS-1:0] rise_r, rise_l, ev;
  logic [NUM_PLAYERS-1:0] pop, byp, push;

  // Both buttons rising together cancel out; one rising while the other is held still counts.
  assign rise_r = turn_right & ~btn_r_q;
  assign rise_l = turn_left & ~btn_l_q;
  assign ev     = rise_r ^ rise_l;

  function automatic logic [2:0] apply_turn(input logic [2:0] cur, input logic left);
    directions nxt;
    case (cur)
      WAIT:    nxt = left ? LEFT  : RIGHT;
      RIGHT:   nxt = left ? UP    : DOWN;
      DOWN:    nxt = left ? RIGHT : LEFT;
      LEFT:    nxt = left ? DOWN  : UP;
      UP:      nxt = left ? LEFT  : RIGHT;
      default: nxt = WAIT;
    endcase
    return nxt;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_comb begin
    btn_r_d          = turn_right;
    btn_l_d          = turn_left;
    mem_d            = mem_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    direction_d      = direction_q;
    dir_changed_d    = '0;
    queue_overflow_d = '0;
    pop              = '0;
    byp              = '0;
    push             = '0;

    for (int p = 0; p < NUM_PLAYERS; p++) begin
      pop[p] = tick && (count_q[p] != '0);
`ifdef DIR_CTRL_BYPASS_EN
      byp[p] = tick && (count_q[p] == '0) && ev[p];
`else
      byp[p] = 1'b0;
`endif
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
      push[p] = ev[p] && !byp[p] && (pop[p] || (count_q[p] != CNT_FULL));
      queue_overflow_d[p] = ev[p] && !byp[p] && !push[p];

      if (pop[p]) begin
        direction_d[p] = apply_turn(direction_q[p], mem_q[p][rd_ptr_q[p]]);
        rd_ptr_d[p]    = next_ptr(rd_ptr_q[p]);
      end else if (byp[p]) begin
        direction_d[p] = apply_turn(direction_q[p], rise_l[p]);
      end else if (tick && (direction_q[p] > 3'(LEFT))) begin
        direction_d[p] = 3'(WAIT);
      end

      if (push[p]) begin
        mem_d[p][wr_ptr_q[p]] = rise_l[p];
        wr_ptr_d[p]           = next_ptr(wr_ptr_q[p]);
      end

      count_d[p]       = count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      dir_changed_d[p] = (direction_d[p] != direction_q[p]);
    end

    if (restart) begin
      btn_r_d          = '0;
      btn_l_d          = '0;
      mem_d            = '0;
      rd_ptr_d         = '0;
      wr_ptr_d         = '0;
      count_d          = '0;
      direction_d      = '0;
      dir_changed_d    = '0;
      queue_overflow_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_r_q          <= '0;
      btn_l_q          <= '0;
      mem_q            <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      direction_q      <= '0;
      dir_changed_q    <= '0;
      queue_overflow_q <= '0;
    end else begin
      btn_r_q          <= btn_r_d;
      btn_l_q          <= btn_l_d;
      mem_q            <= mem_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      direction_q      <= direction_d;
      dir_changed_q    <= dir_changed_d;
      queue_overflow_q <= queue_overflow_d;
    end
  end

  assign direction      = direction_q;
  assign dir_changed    = dir_changed_q;
  assign queue_overflow = queue_overflow_q;

endmodule

// File: tb/tb_snake_turn_queue_ctrl.sv
// Bench for snake_turn_queue_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_snake_turn_queue_ctrl;
  import game_pkg::*;

  localparam int NP = 2;
  localparam int QD = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              restart = 1'b0;
  logic              tick = 1'b0;
  logic [NP-1:0]     turn_right = '0;
  logic [NP-1:0]     turn_left = '0;
  logic [NP-1:0][2:0] direction;
  logic [NP-1:0]     dir_changed;
  logic [NP-1:0]     queue_overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of pending turns per player and a compass heading.
  bit        m_q[NP][$];
  directions m_dir[NP];
  bit        m_pr[NP];
  bit        m_pl[NP];
  bit [NP-1:0] m_chg;
  bit [NP-1:0] m_ovf;

  snake_turn_queue_ctrl #(.NUM_PLAYERS(NP), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .restart(restart), .tick(tick),
    .turn_right(turn_right), .turn_left(turn_left),
    .direction(direction), .dir_changed(dir_changed), .queue_overflow(queue_overflow)
  );

  always #5 clk = ~clk;

  // Clockwise compass order; a right turn steps forward, a left turn steps back.
  function automatic directions turn_model(input directions d, input bit left);
    directions ring[4];
    int idx;
    ring[0] = UP; ring[1] = RIGHT; ring[2] = DOWN; ring[3] = LEFT;
    idx = -1;
    for (int i = 0; i < 4; i++) if (ring[i] == d) idx = i;
    if (idx < 0) return left ? LEFT : RIGHT;
    return ring[left ? (idx + 3) % 4 : (idx + 1) % 4];
  endfunction

  task automatic model_update();
    bit er, el, ev, used;
    directions old;
    for (int p = 0; p < NP; p++) begin
      if (rst || restart) begin
        m_q[p].delete();
        m_dir[p] = WAIT;
        m_chg[p] = 1'b0;
        m_ovf[p] = 1'b0;
        m_pr[p]  = 1'b0;
        m_pl[p]  = 1'b0;
      end else begin
        er = turn_right[p] && !m_pr[p];
        el = turn_left[p] && !m_pl[p];
        ev = (er != el);
        used = 1'b0;
        old = m_dir[p];
        m_ovf[p] = 1'b0;
        if (tick) begin
          if (m_q[p].size() > 0) m_dir[p] = turn_model(m_dir[p], m_q[p].pop_front());
`ifdef DIR_CTRL_BYPASS_EN
          else if (ev) begin
            m_dir[p] = turn_model(m_dir[p], el);
            used = 1'b1;
          end
`endif
        end
        if (ev && !used) begin
          if (m_q[p].size() < QD) m_q[p].push_back(el);
          else m_ovf[p] = 1'b1;
        end
        m_chg[p] = (m_dir[p] != old);
        m_pr[p] = turn_right[p];
        m_pl[p] = turn_left[p];
      end
    end
  endtask

  task automatic cyc(input logic [NP-1:0] tr, input logic [NP-1:0] tl,
                     input logic tk, input logic rs, input logic rsti);
    turn_right = tr;
    turn_left  = tl;
    tick       = tk;
    restart    = rs;
    rst        = rsti;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic click(input logic [NP-1:0] tr, input logic [NP-1:0] tl);
    cyc(tr, tl, 1'b0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [NP-1:0][2:0] exp;
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, 2'b01, 1'(i % 2), 1'b0, 1'b1);
      checks++;
      if (direction !== '0 || dir_changed !== '0 || queue_overflow !== '0) begin
        errors++;
        $display("FAIL reset_state: dir=%h chg=%b ovf=%b, required dir=0 chg=0 ovf=0",
                 direction, dir_changed, queue_overflow);
      end
    end
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (direction !== '0 || dir_changed !== '0) begin
      errors++;
      $display("FAIL reset_release: dir=%h chg=%b, required WAIT and no pulse", direction, dir_changed);
    end
    cyc(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
    exp = {RIGHT, RIGHT};
    checks++;
    if (direction !== exp || dir_changed !== 2'b11) begin
      errors++;
      $display("FAIL first_tick: dir=%h chg=%b, required dir=%h chg=11", direction, dir_changed, exp);
    end
    cyc(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (direction !== exp || dir_changed !== 2'b00) begin
      errors++;
      $display("FAIL held_single_event: dir=%h chg=%b, required dir=%h chg=00", direction, dir_changed, exp);
    end
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dir_changed !== 2'b00) begin
      errors++;
      $display("FAIL changed_one_cycle: chg=%b, required 00", dir_changed);
    end
  endtask

  task automatic test_turn_sequence();
    directions seq_r[4];
    directions seq_l[4];
    seq_r[0] = DOWN; seq_r[1] = LEFT; seq_r[2] = UP;   seq_r[3] = RIGHT;
    seq_l[0] = UP;   seq_l[1] = LEFT; seq_l[2] = DOWN; seq_l[3] = RIGHT;
    // Phase 0: P0 turns right, P1 turns left; phase 1 swaps them.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 4; i++) click(ph == 0 ? 2'b01 : 2'b10, ph == 0 ? 2'b10 : 2'b01);
      for (int i = 0; i < 4; i++) begin
        cyc('0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (direction[0] !== (ph == 0 ? seq_r[i] : seq_l[i]) ||
            direction[1] !== (ph == 0 ? seq_l[i] : seq_r[i]) || dir_changed !== 2'b11) begin
          errors++;
          $display("FAIL turn_seq ph%0d step%0d: p0=%0d p1=%0d chg=%b, required p0=%0d p1=%0d chg=11",
                   ph, i, direction[0], direction[1], dir_changed,
                   ph == 0 ? seq_r[i] : seq_l[i], ph == 0 ? seq_l[i] : seq_r[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    directions seq_r[4];
    int pulses;
    seq_r[0] = DOWN; seq_r[1] = LEFT; seq_r[2] = UP; seq_r[3] = RIGHT;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
      if (queue_overflow[0]) pulses++;
      checks++;
      if (queue_overflow !== (i == 4 ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL overflow_click%0d: ovf=%b, required %b", i, queue_overflow, i == 4 ? 2'b01 : 2'b00);
      end
      cyc('0, '0, 1'b0, 1'b0, 1'b0);
      if (queue_overflow[0]) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL overflow_pulse_count: got %0d, required 1", pulses);
    end
    for (int i = 0; i < 5; i++) begin
      cyc('0, '0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (direction[0] !== (i < 4 ? seq_r[i] : RIGHT) || dir_changed !== (i < 4 ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL overflow_drain%0d: p0=%0d chg=%b, required p0=%0d chg=%b", i, direction[0],
                 dir_changed, i < 4 ? seq_r[i] : RIGHT, i < 4 ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_simultaneous();
    directions seq[4];
    seq[0] = LEFT; seq[1] = UP; seq[2] = RIGHT; seq[3] = DOWN;
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    cyc('0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (direction[0] !== RIGHT || dir_changed !== 2'b00) begin
      errors++;
      $display("FAIL both_rising_ignored: p0=%0d chg=%b, required p0=%0d chg=00", direction[0], dir_changed, RIGHT);
    end
    for (int i = 0; i < 4; i++) click(2'b01, 2'b00);
    cyc(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (queue_overflow !== 2'b00 || direction[0] !== DOWN || dir_changed !== 2'b01) begin
      errors++;
      $display("FAIL full_tick_click: ovf=%b p0=%0d chg=%b, required ovf=00 p0=%0d chg=01",
               queue_overflow, direction[0], dir_changed, DOWN);
    end
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (queue_overflow !== 2'b01) begin
      errors++;
      $display("FAIL occupancy_still_full: ovf=%b, required 01", queue_overflow);
    end
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc('0, '0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (direction[0] !== (i < 4 ? seq[i] : DOWN) || dir_changed !== (i < 4 ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL simult_drain%0d: p0=%0d chg=%b, required p0=%0d chg=%b", i, direction[0],
                 dir_changed, i < 4 ? seq[i] : DOWN, i < 4 ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_bypass();
    logic [NP-1:0] exp_chg1, exp_chg2;
    directions exp_dir1;
`ifdef DIR_CTRL_BYPASS_EN
    exp_dir1 = LEFT; exp_chg1 = 2'b01; exp_chg2 = 2'b00;
`else
    exp_dir1 = DOWN; exp_chg1 = 2'b00; exp_chg2 = 2'b01;
`endif
    cyc(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (direction[0] !== exp_dir1 || dir_changed !== exp_chg1 || direction[1] !== RIGHT) begin
      errors++;
      $display("FAIL bypass_tick: p0=%0d p1=%0d chg=%b, required p0=%0d p1=%0d chg=%b",
               direction[0], direction[1], dir_changed, exp_dir1, RIGHT, exp_chg1);
    end
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    cyc('0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (direction[0] !== LEFT || dir_changed !== exp_chg2) begin
      errors++;
      $display("FAIL bypass_next_tick: p0=%0d chg=%b, required p0=%0d chg=%b",
               direction[0], dir_changed, LEFT, exp_chg2);
    end
  endtask

  task automatic test_restart();
    click(2'b01, 2'b00);
    click(2'b01, 2'b00);
    click(2'b00, 2'b10);
    cyc('0, '0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (direction !== '0 || dir_changed !== '0 || queue_overflow !== '0) begin
      errors++;
      $display("FAIL restart_state: dir=%h chg=%b ovf=%b, required 0/0/0", direction, dir_changed, queue_overflow);
    end
    cyc('0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (direction !== '0 || dir_changed !== '0) begin
      errors++;
      $display("FAIL restart_discard: dir=%h chg=%b, required WAIT and no change", direction, dir_changed);
    end
  endtask

  task automatic test_random();
    logic [NP-1:0] tr, tl;
    logic tk, rs, rsti;
    logic [NP-1:0][2:0] exp;
    tr = '0; tl = '0;
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) == 0) tr[p] = ~tr[p];
        if ($urandom_range(0, 2) == 0) tl[p] = ~tl[p];
      end
      tk   = (i < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      rs   = ($urandom_range(0, 149) == 0);
      rsti = ($urandom_range(0, 299) == 0);
      cyc(tr, tl, tk, rs, rsti);
      for (int p = 0; p < NP; p++) exp[p] = m_dir[p];
      checks++;
      if (direction !== exp || dir_changed !== m_chg || queue_overflow !== m_ovf) begin
        errors++;
        $display("FAIL random_cycle%0d: dir=%h chg=%b ovf=%b, required dir=%h chg=%b ovf=%b",
                 i, direction, dir_changed, queue_overflow, exp, m_chg, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_turn_sequence();
    test_overflow();
    test_simultaneous();
    test_bypass();
    test_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
